uart_tx_arb: RTL

Round-robin arbiter and sequencer that shares one `uart_tx` serialiser between `NUM_REQ` byte-stream requesters. Each requester offers bytes over a valid/ready handshake with a `last` marker. The block locks the grant for a whole message, capped at `MAX_BURST` bytes, and issues one `tx_start` pulse per byte. It paces transmission on the `uart_tx` busy flag. It sits between the host-side command/log sources and the transmit half of the UART, mirroring the `uart_rx` datapath.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arb_if.sv | 30 +++
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arb.sv | 100 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, baud constants and the transmit-arbiter state type.
// Used by uart_rx, uart_tx and uart_tx_arb.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLK_HZ       = 50_000_000;
    localparam int UART_BAUD         = 115_200;
    localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } uart_arb_state_e;

    // Index increment that wraps at n (n need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester streams and uart_tx handshake bundled for the transmit arbiter.
// master is the arbiter side; slave is the requesters plus the serialiser.
interface uart_tx_arb_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W,
    localparam int GW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic [GW-1:0]             grant_id;
    logic                      grant_active;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, grant_active
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, grant_active
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first asserted req index at or after ptr, wrapping modulo N.
// Purely combinational; lower offset from ptr wins.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N   = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW:0] cand;

    // Walk offsets from the far end so the nearest candidate is the last one written.
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = (PW+1)'(int'(ptr) + i);
            if (32'(cand) >= N) begin
                cand = cand - (PW+1)'(N);
            end
            if (req[cand[PW-1:0]]) begin
                idx = cand[PW-1:0];
            end
        end
        any = |req;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx between NUM_REQ byte streams: grant locked per message (capped at
// MAX_BURST bytes), one tx_start per byte, paced on tx_busy.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no owner; arbitrate round-robin from rr_ptr
//   SEND      | owner holds grant; accept its next byte once tx_busy is low
//   WAIT_BUSY | tx_start issued; wait for uart_tx to raise busy
//   WAIT_IDLE | frame in flight; on busy fall release or fetch next byte
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = UART_DATA_W,
    parameter int MAX_BURST = 16,
    localparam int GW       = $clog2(NUM_REQ)
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_arb_if.master  bus
);

    uart_arb_state_e    state, state_next;
    logic [GW-1:0]      rr_ptr, pick_idx, grant_q, next_ptr;
    logic               pick_any, owner_valid, handshake, release_now, last_q;
    logic [7:0]         burst_cnt;
    logic [DATA_W-1:0]  tx_data_q;
    logic               tx_start_q;
    logic [NUM_REQ-1:0] ready;
    logic               active;

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_valid = bus.req_valid[grant_q];
    assign handshake   = (state == SEND) && owner_valid && !bus.tx_busy;
    assign release_now = last_q || (burst_cnt == 8'(MAX_BURST));
    assign next_ptr    = GW'(wrap_inc(32'(grant_q), NUM_REQ));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (pick_any) state_next = SEND;
            SEND:      if (handshake) state_next = WAIT_BUSY;
            WAIT_BUSY: if (bus.tx_busy) state_next = WAIT_IDLE;
            WAIT_IDLE: if (!bus.tx_busy) state_next = release_now ? IDLE : SEND;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        ready  = '0;
        if (state == SEND) begin
            ready[grant_q] = owner_valid && !bus.tx_busy;
        end
        active = (state != IDLE);
    end

    // burst_cnt cannot pass MAX_BURST: the grant is released on reaching it.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= '0;
            rr_ptr     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            last_q     <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            tx_start_q <= handshake;
            if (state == IDLE && pick_any) begin
                grant_q <= pick_idx;
            end
            if (handshake) begin
                tx_data_q <= bus.req_data[int'(grant_q)*DATA_W +: DATA_W];
                last_q    <= bus.req_last[grant_q];
                burst_cnt <= burst_cnt + 8'd1;
            end
            if (state == WAIT_IDLE && !bus.tx_busy && release_now) begin
                rr_ptr    <= next_ptr;
                burst_cnt <= '0;
            end
        end
    end

    assign bus.req_ready    = ready;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.grant_id     = grant_q;
    assign bus.grant_active = active;

endmodule
